seg7_scan_capture: RTL

Receiving end of the seven-segment display interface: watches a time-multiplexed active-low anode/segment bus and recovers the 4-bit display code shown on each digit. Each scan slot must hold steady for a qualification period before it is accepted. Used as an in-system display monitor and as the bench-side checker for the clock/calendar display path. Segment patterns are mapped back to codes using the team's seg7 code set, including A/P, dash, blank and triple-dash.

---
 rtl/seg7_pkg.sv | 35 +++
 rtl/seg7_pattern_decode.sv | 38 +++
 rtl/seg7_scan_capture.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared seg7 code set: display codes, active-low segment patterns (abcdefg, a = MSB)
// and the scan-capture FSM states.
package seg7_pkg;

  localparam logic [3:0] CODE_A      = 4'hA;
  localparam logic [3:0] CODE_P      = 4'hB;
  localparam logic [3:0] CODE_DASH   = 4'hC;
  localparam logic [3:0] CODE_TRIPLE = 4'hD;
  localparam logic [3:0] CODE_BAD    = 4'hE;
  localparam logic [3:0] CODE_OFF    = 4'hF;

  localparam logic [6:0] PAT_0      = 7'b0000001;
  localparam logic [6:0] PAT_1      = 7'b1001111;
  localparam logic [6:0] PAT_2      = 7'b0010010;
  localparam logic [6:0] PAT_3      = 7'b0000110;
  localparam logic [6:0] PAT_4      = 7'b1001100;
  localparam logic [6:0] PAT_5      = 7'b0100100;
  localparam logic [6:0] PAT_6      = 7'b0100000;
  localparam logic [6:0] PAT_7      = 7'b0001111;
  localparam logic [6:0] PAT_8      = 7'b0000000;
  localparam logic [6:0] PAT_9      = 7'b0000100;
  localparam logic [6:0] PAT_A      = 7'b0001000;
  localparam logic [6:0] PAT_P      = 7'b0011000;
  localparam logic [6:0] PAT_DASH   = 7'b1111110;
  localparam logic [6:0] PAT_TRIPLE = 7'b0110110;
  localparam logic [6:0] PAT_OFF    = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_CONFLICT = 2'd3
  } scan_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the seg7 encoder: segment pattern -> display code,
// with a flag for patterns outside the code set.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       invalid
);

  // Pattern lookup; unknown patterns map to the bad code.
  always_comb begin
    code    = CODE_BAD;
    invalid = 1'b0;
    case (seg)
      PAT_0:      code = 4'h0;
      PAT_1:      code = 4'h1;
      PAT_2:      code = 4'h2;
      PAT_3:      code = 4'h3;
      PAT_4:      code = 4'h4;
      PAT_5:      code = 4'h5;
      PAT_6:      code = 4'h6;
      PAT_7:      code = 4'h7;
      PAT_8:      code = 4'h8;
      PAT_9:      code = 4'h9;
      PAT_A:      code = CODE_A;
      PAT_P:      code = CODE_P;
      PAT_DASH:   code = CODE_DASH;
      PAT_TRIPLE: code = CODE_TRIPLE;
      PAT_OFF:    code = CODE_OFF;
      default: begin
        code    = CODE_BAD;
        invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Display-bus monitor: qualifies each multiplexed scan slot for STABLE_CYCLES
// identical samples, then stores the decoded code of the selected digit.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int N_DIGITS      = 6,
  parameter int STABLE_CYCLES = 4,
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_DIGITS-1:0]   an,
  input  logic [6:0]            seg,
  output logic [4*N_DIGITS-1:0] digits,
  output logic [N_DIGITS-1:0]   digit_valid,
  output logic                  update,
  output logic [IW-1:0]         upd_idx,
  output logic                  bad_pattern,
  output logic                  bad_select
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);

  logic [N_DIGITS-1:0] an_r;
  logic [6:0]          seg_r;
  logic [N_DIGITS-1:0] an_prev_r;
  logic [6:0]          seg_prev_r;

  logic                changed_s;
  logic                all_high_s;
  logic                one_hot_s;
  logic [IW-1:0]       idx_s;
  logic [3:0]          code_s;
  logic                invalid_s;

  scan_state_e         state_r;
  scan_state_e         state_nxt_s;
  logic [CW-1:0]       count_r;
  logic [CW-1:0]       count_nxt_s;
  logic [CW-1:0]       cnt_inc_s;
  logic                capture_s;
  logic                conflict_entry_s;

  logic [3:0]          digits_r [N_DIGITS];

  // Input stage plus one-sample history for the change comparator; resets to an idle bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_r       <= '1;
      seg_r      <= 7'h7F;
      an_prev_r  <= '1;
      seg_prev_r <= 7'h7F;
    end else begin
      an_r       <= an;
      seg_r      <= seg;
      an_prev_r  <= an_r;
      seg_prev_r <= seg_r;
    end
  end

  assign changed_s  = (an_r != an_prev_r) || (seg_r != seg_prev_r);
  assign all_high_s = &an_r;
  assign one_hot_s  = $onehot(~an_r);

  // Anode-to-index encoder; only meaningful when exactly one anode is low.
  always_comb begin
    idx_s = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      idx_s = (!an_r[i]) ? IW'(i) : idx_s;
    end
  end

  seg7_pattern_decode u_decode (
    .seg     (seg_r),
    .code    (code_s),
    .invalid (invalid_s)
  );

  // State and qualification counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      count_r <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  assign cnt_inc_s = (count_r >= CNT_MAX) ? CNT_MAX : (count_r + CNT_ONE);

  // A changed sample restarts by anode class; otherwise only SETTLE makes progress.
  always_comb begin
    state_nxt_s      = state_r;
    count_nxt_s      = count_r;
    capture_s        = 1'b0;
    conflict_entry_s = 1'b0;
    if (changed_s) begin
      if (all_high_s) begin
        state_nxt_s = ST_IDLE;
        count_nxt_s = CNT_ZERO;
      end else if (one_hot_s) begin
        count_nxt_s = CNT_ONE;
        if (CNT_ONE == CNT_MAX) begin
          state_nxt_s = ST_LOCKED;
          capture_s   = 1'b1;
        end else begin
          state_nxt_s = ST_SETTLE;
        end
      end else begin
        state_nxt_s      = ST_CONFLICT;
        count_nxt_s      = CNT_ZERO;
        conflict_entry_s = 1'b1;
      end
    end else begin
      case (state_r)
        ST_SETTLE: begin
          count_nxt_s = cnt_inc_s;
          if (cnt_inc_s == CNT_MAX) begin
            state_nxt_s = ST_LOCKED;
            capture_s   = 1'b1;
          end else begin
            state_nxt_s = ST_SETTLE;
          end
        end
        default: begin
          state_nxt_s = state_r;
          count_nxt_s = count_r;
        end
      endcase
    end
  end

  // Digit register file and registered event pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        digits_r[i] <= CODE_OFF;
      end
      digit_valid <= '0;
      update      <= 1'b0;
      upd_idx     <= '0;
      bad_pattern <= 1'b0;
      bad_select  <= 1'b0;
    end else begin
      update      <= 1'b0;
      bad_pattern <= 1'b0;
      bad_select  <= conflict_entry_s;
      if (capture_s) begin
        digits_r[idx_s]    <= code_s;
        digit_valid[idx_s] <= 1'b1;
        update             <= (digits_r[idx_s] != code_s) || !digit_valid[idx_s];
        upd_idx            <= idx_s;
        bad_pattern        <= invalid_s;
      end
    end
  end

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_flat
    assign digits[4*g +: 4] = digits_r[g];
  end

endmodule
